// File: rtl/vga_tile_pkg.sv
// Shared constants and types for the VGA tile renderer.
// Optional feature macro used by the renderer: VGA_TILE_BLINK_EN.
package vga_tile_pkg;

    localparam int COLS       = 40;
    localparam int ROWS       = 30;
    localparam int TILE_LOG2  = 4;
    localparam int SMEM_DEPTH = 1200;
    localparam int PIPE_LAT   = 4;

    // One 4:4:4 pixel, red in the most significant nibble.
    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

endpackage

// File: rtl/vga_tile_renderer_sync_delay.sv
// sync_delay: N-stage, W-bit shift register with synchronous active-low
// reset and a per-bit reset value. Carries the timer side-band signals
// (syncs, active, tile offsets, blink attribute) alongside the pixel.
module sync_delay #(
    parameter int             N       = 1,
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_stage [N];

    // Shift every stage by one each clock; reset loads the idle value.
    // NOTE: sequential state uses <= so each stage samples the pre-edge value of its neighbour.
    always_ff @(posedge clk) begin
        // NOTE: these stages are individual flops, not a memory array, so each one can be reset.
        if (!reset_n) begin
            for (int i = 0; i < N; i++) r_stage[i] <= RST_VAL;
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < N; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign o_q = r_stage[N-1];

endmodule

// File: rtl/vga_tile_renderer.sv
// vga_tile_renderer: four-stage pixel pipeline behind the VGA timer.
//   S1 tile address -> S2 bitmap address -> S3 bitmap read -> S4 RGB out.
// Syncs travel through the same four stages so they stay aligned with colour.
// Optional feature: define VGA_TILE_BLINK_EN to use the character MSB as a
// blink attribute (pixel black while frame_count[5] is set).
`ifndef XBITS
`define XBITS 10
`endif
`ifndef YBITS
`define YBITS 10
`endif

module vga_tile_renderer #(
    parameter int CHAR_BITS      = 4,
    parameter int TILE_LOG2      = 4,
    parameter int COLS           = 40,
    parameter int SMEM_ADDR_BITS = 11,
    parameter int FRAME_BITS     = 8
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [`XBITS-1:0]               x,
    input  logic [`YBITS-1:0]               y,
    input  logic                            hsync_in,
    input  logic                            vsync_in,
    input  logic                            activevideo_in,
    output logic [SMEM_ADDR_BITS-1:0]       smem_addr,
    input  logic [CHAR_BITS-1:0]            smem_data,
    output logic [CHAR_BITS+2*TILE_LOG2-1:0] bmem_addr,
    input  logic [11:0]                     bmem_color,
    output logic [3:0]                      red,
    output logic [3:0]                      green,
    output logic [3:0]                      blue,
    output logic                            hsync,
    output logic                            vsync,
    output logic [FRAME_BITS-1:0]           frame_count
);

    import vga_tile_pkg::*;

    localparam int OFF_W = 2 * TILE_LOG2;

    logic [SMEM_ADDR_BITS-1:0]        w_row;
    logic [SMEM_ADDR_BITS-1:0]        w_col;
    logic [SMEM_ADDR_BITS-1:0]        w_tile_addr;
    logic [SMEM_ADDR_BITS-1:0]        r_smem_addr;
    logic [OFF_W-1:0]                 w_off_s1;
    logic [2:0]                       w_ctl_s3;
    logic                             w_hsync_s3;
    logic                             w_vsync_s3;
    logic                             w_active_s3;
    logic [CHAR_BITS-1:0]             w_char;
    logic [CHAR_BITS+OFF_W-1:0]       r_bmem_addr;
    rgb444_t                          w_pixel;
    rgb444_t                          r_rgb;
    logic                             r_hsync;
    logic                             r_vsync;
    logic                             w_vsync_fall;
    logic [FRAME_BITS-1:0]            r_frame_count;

    // Tile row/column; the constant multiply by 40 reduces to row*32 + row*8.
    assign w_row       = SMEM_ADDR_BITS'(y >> TILE_LOG2);
    assign w_col       = SMEM_ADDR_BITS'(x >> TILE_LOG2);
    assign w_tile_addr = w_row * SMEM_ADDR_BITS'(COLS) + w_col;

    // S1: screen-memory address, parked at 0 during blanking so it stays below 1200.
    always_ff @(posedge clk) begin
        if (!reset_n) r_smem_addr <= '0;
        else          r_smem_addr <= activevideo_in ? w_tile_addr : '0;
    end

    // Pixel offsets inside the tile are needed one stage later, at S2.
    sync_delay #(.N(1), .W(OFF_W), .RST_VAL('0)) u_off_delay (
        .clk     (clk),
        .reset_n (reset_n),
        .i_d     ({y[TILE_LOG2-1:0], x[TILE_LOG2-1:0]}),
        .o_q     (w_off_s1)
    );

    // Syncs idle high, active idles low; three stages bring them to S3.
    sync_delay #(.N(3), .W(3), .RST_VAL(3'b110)) u_ctl_delay (
        .clk     (clk),
        .reset_n (reset_n),
        .i_d     ({hsync_in, vsync_in, activevideo_in}),
        .o_q     (w_ctl_s3)
    );

    assign {w_hsync_s3, w_vsync_s3, w_active_s3} = w_ctl_s3;

`ifdef VGA_TILE_BLINK_EN
    logic w_attr_s3;

    // The character MSB is the blink attribute; only the low bits index glyphs.
    assign w_char = {1'b0, smem_data[CHAR_BITS-2:0]};

    // Attribute enters at S2 with the character and is used at S4.
    sync_delay #(.N(2), .W(1), .RST_VAL(1'b0)) u_attr_delay (
        .clk     (clk),
        .reset_n (reset_n),
        .i_d     (smem_data[CHAR_BITS-1]),
        .o_q     (w_attr_s3)
    );
`else
    assign w_char = smem_data;
`endif

    // S2: bitmap address = {character, row in tile, column in tile}.
    always_ff @(posedge clk) begin
        if (!reset_n) r_bmem_addr <= '0;
        else          r_bmem_addr <= {w_char, w_off_s1};
    end

    // S4 colour select: black in blanking (and while a blinking glyph is off).
    always_comb begin
        // NOTE: default assignment first so no path leaves w_pixel unassigned (no latch).
        w_pixel = '0;
        if (w_active_s3) w_pixel = bmem_color;
`ifdef VGA_TILE_BLINK_EN
        if (w_attr_s3 && r_frame_count[5]) w_pixel = '0;
`endif
    end

    // S4: registered colour and syncs, all leaving on the same edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rgb   <= '0;
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
        end else begin
            r_rgb   <= w_pixel;
            r_hsync <= w_hsync_s3;
            r_vsync <= w_vsync_s3;
        end
    end

    // The output vsync register doubles as the previous-vsync_s3 value.
    assign w_vsync_fall = !w_vsync_s3 && r_vsync;

    // Completed-frame counter, wrapping naturally at 2^FRAME_BITS.
    always_ff @(posedge clk) begin
        if (!reset_n)          r_frame_count <= '0;
        else if (w_vsync_fall) r_frame_count <= r_frame_count + FRAME_BITS'(1);
    end

    assign smem_addr   = r_smem_addr;
    assign bmem_addr   = r_bmem_addr;
    assign red         = r_rgb.r;
    assign green       = r_rgb.g;
    assign blue        = r_rgb.b;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_tile_renderer.sv
// Directed bench for vga_tile_renderer: reset, tile addressing and latency,
// sync alignment, mid-line reset, frame counter wrap, character index /
// blink attribute (VGA_TILE_BLINK_EN), and a memory-model scoreboard.
`timescale 1ns/1ps
`ifndef XBITS
`define XBITS 10
`endif
`ifndef YBITS
`define YBITS 10
`endif

module tb_vga_tile_renderer;
    import vga_tile_pkg::*;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [`XBITS-1:0]  x;
    logic [`YBITS-1:0]  y;
    logic               hsync_in;
    logic               vsync_in;
    logic               activevideo_in;
    logic [10:0]        smem_addr;
    logic [3:0]         smem_data;
    logic [11:0]        bmem_addr;
    logic [11:0]        bmem_color;
    logic [3:0]         red, green, blue;
    logic               hsync, vsync;
    logic [7:0]         frame_count;

    logic               use_model;
    logic [3:0]         drv_smem;
    logic [11:0]        drv_bmem;
    logic [3:0]         smem_mem [2048];
    logic [11:0]        bmem_mem [4096];
    logic [3:0]         smem_q;
    logic [11:0]        bmem_q;

    int errors    = 0;
    int checks    = 0;
    int exp_frame = 0;

    always #5 clk = ~clk;

    // Synchronous-read memory models.
    always @(posedge clk) begin
        smem_q <= smem_mem[smem_addr];
        bmem_q <= bmem_mem[bmem_addr];
    end

    assign smem_data  = use_model ? smem_q : drv_smem;
    assign bmem_color = use_model ? bmem_q : drv_bmem;

    vga_tile_renderer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .x              (x),
        .y              (y),
        .hsync_in       (hsync_in),
        .vsync_in       (vsync_in),
        .activevideo_in (activevideo_in),
        .smem_addr      (smem_addr),
        .smem_data      (smem_data),
        .bmem_addr      (bmem_addr),
        .bmem_color     (bmem_color),
        .red            (red),
        .green          (green),
        .blue           (blue),
        .hsync          (hsync),
        .vsync          (vsync),
        .frame_count    (frame_count)
    );

    typedef struct {
        int          px;
        int          py;
        logic        act;
        logic [10:0] smem;
        logic [11:0] bmem;
        logic [11:0] rgb3;
        logic [11:0] rgb4;
    } addr_vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input int px, input int py, input logic act);
        x = `XBITS'(px);
        y = `YBITS'(py);
        activevideo_in = act;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        set_pix(639, 479, 1'b1);
        hsync_in = 1'b0;
        vsync_in = 1'b1;
        tick();
        tick();
        checks++; if (smem_addr !== 11'd0) begin errors++; $display("FAIL reset_smem_addr: got %0d want 0", smem_addr); end
        checks++; if (bmem_addr !== 12'h000) begin errors++; $display("FAIL reset_bmem_addr: got %h want 000", bmem_addr); end
        checks++; if ({red, green, blue} !== 12'h000) begin errors++; $display("FAIL reset_rgb: got %h want 000", {red, green, blue}); end
        checks++; if (hsync !== 1'b1 || vsync !== 1'b1) begin errors++; $display("FAIL reset_sync: got hs=%b vs=%b want 1 1", hsync, vsync); end
        checks++; if (frame_count !== 8'd0) begin errors++; $display("FAIL reset_frame: got %0d want 0", frame_count); end
    endtask

    task automatic test_addr_latency();
        addr_vec_t vecs [7];
        vecs[0] = '{639, 479, 1'b1, 11'd1199, 12'h3FF, 12'h000, 12'hF80};
        vecs[1] = '{16,  16,  1'b1, 11'd41,   12'h300, 12'hF80, 12'hF80};
        vecs[2] = '{15,  17,  1'b1, 11'd40,   12'h31F, 12'hF80, 12'hF80};
        vecs[3] = '{16,  0,   1'b1, 11'd1,    12'h300, 12'hF80, 12'hF80};
        vecs[4] = '{0,   479, 1'b1, 11'd1160, 12'h3F0, 12'hF80, 12'hF80};
        vecs[5] = '{700, 16,  1'b0, 11'd0,    12'h30C, 12'hF80, 12'h000};
        vecs[6] = '{0,   0,   1'b1, 11'd0,    12'h300, 12'h000, 12'hF80};
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        reset_n  = 1'b1;
        for (int i = 0; i < 7; i++) begin
            set_pix(vecs[i].px, vecs[i].py, vecs[i].act);
            tick();
            checks++; if (smem_addr !== vecs[i].smem) begin errors++; $display("FAIL addr_v%0d_smem: got %0d want %0d", i, smem_addr, vecs[i].smem); end
            tick();
            checks++; if (bmem_addr !== vecs[i].bmem) begin errors++; $display("FAIL addr_v%0d_bmem: got %h want %h", i, bmem_addr, vecs[i].bmem); end
            tick();
            checks++; if ({red, green, blue} !== vecs[i].rgb3) begin errors++; $display("FAIL addr_v%0d_rgb_t3: got %h want %h", i, {red, green, blue}, vecs[i].rgb3); end
            tick();
            checks++; if ({red, green, blue} !== vecs[i].rgb4) begin errors++; $display("FAIL addr_v%0d_rgb_t4: got %h want %h", i, {red, green, blue}, vecs[i].rgb4); end
        end
    endtask

    task automatic test_sync();
        hsync_in = 1'b0;
        tick(); tick(); tick();
        checks++; if (hsync !== 1'b1) begin errors++; $display("FAIL hsync_fall_t3: got %b want 1", hsync); end
        tick();
        checks++; if (hsync !== 1'b0) begin errors++; $display("FAIL hsync_fall_t4: got %b want 0", hsync); end
        hsync_in = 1'b1;
        tick(); tick(); tick();
        checks++; if (hsync !== 1'b0) begin errors++; $display("FAIL hsync_rise_t3: got %b want 0", hsync); end
        tick();
        checks++; if (hsync !== 1'b1) begin errors++; $display("FAIL hsync_rise_t4: got %b want 1", hsync); end
        vsync_in = 1'b0;
        tick(); tick(); tick();
        checks++; if (vsync !== 1'b1 || frame_count !== 8'(exp_frame)) begin errors++; $display("FAIL vsync_fall_t3: got vs=%b fc=%0d want 1 %0d", vsync, frame_count, exp_frame); end
        tick();
        exp_frame++;
        checks++; if (vsync !== 1'b0 || frame_count !== 8'(exp_frame)) begin errors++; $display("FAIL vsync_fall_t4: got vs=%b fc=%0d want 0 %0d", vsync, frame_count, exp_frame); end
        vsync_in = 1'b1;
        tick(); tick(); tick(); tick();
        checks++; if (vsync !== 1'b1 || frame_count !== 8'(exp_frame)) begin errors++; $display("FAIL vsync_rise: got vs=%b fc=%0d want 1 %0d", vsync, frame_count, exp_frame); end
    endtask

    task automatic test_reset_mid();
        set_pix(0, 0, 1'b1);
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        tick(); tick(); tick(); tick();
        reset_n = 1'b0;
        tick();
        checks++; if ({red, green, blue} !== 12'h000) begin errors++; $display("FAIL midrst_rgb: got %h want 000", {red, green, blue}); end
        checks++; if (hsync !== 1'b1 || vsync !== 1'b1) begin errors++; $display("FAIL midrst_sync: got hs=%b vs=%b want 1 1", hsync, vsync); end
        checks++; if (frame_count !== 8'd0) begin errors++; $display("FAIL midrst_frame: got %0d want 0", frame_count); end
        tick();
        reset_n = 1'b1;
        tick();
        checks++; if (frame_count !== 8'd0) begin errors++; $display("FAIL midrst_first_clk_frame: got %0d want 0", frame_count); end
        tick(); tick();
        checks++; if ({red, green, blue} !== 12'h000 || hsync !== 1'b1 || frame_count !== 8'd0) begin errors++; $display("FAIL midrst_t3: got rgb=%h hs=%b fc=%0d want 000 1 0", {red, green, blue}, hsync, frame_count); end
        tick();
        exp_frame = 1;
        checks++; if ({red, green, blue} !== 12'hF80 || hsync !== 1'b0 || vsync !== 1'b0 || frame_count !== 8'd1) begin errors++; $display("FAIL midrst_t4: got rgb=%h hs=%b vs=%b fc=%0d want f80 0 0 1", {red, green, blue}, hsync, vsync, frame_count); end
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        tick(); tick(); tick(); tick();
    endtask

    task automatic test_frame_count();
        reset_n  = 1'b0;
        vsync_in = 1'b1;
        tick(); tick();
        reset_n = 1'b1;
        tick();
        checks++; if (frame_count !== 8'd0) begin errors++; $display("FAIL frame_after_reset: got %0d want 0", frame_count); end
        for (int k = 1; k <= 256; k++) begin
            vsync_in = 1'b0;
            tick(); tick(); tick(); tick();
            checks++; if (frame_count !== 8'(k % 256)) begin errors++; $display("FAIL frame_pulse%0d: got %0d want %0d", k, frame_count, k % 256); end
            vsync_in = 1'b1;
            tick(); tick(); tick(); tick();
        end
        exp_frame = 0;
    endtask

    task automatic test_char_index();
        set_pix(0, 0, 1'b1);
        drv_smem = 4'b1010;
        tick(); tick(); tick(); tick();
`ifdef VGA_TILE_BLINK_EN
        checks++; if (bmem_addr !== 12'h200) begin errors++; $display("FAIL blink_bmem_msb: got %h want 200", bmem_addr); end
        checks++; if ({red, green, blue} !== 12'hF80) begin errors++; $display("FAIL blink_shown: got %h want f80", {red, green, blue}); end
        for (int k = 0; k < 32; k++) begin
            vsync_in = 1'b0;
            tick(); tick(); tick(); tick();
            vsync_in = 1'b1;
            tick(); tick(); tick(); tick();
        end
        exp_frame = 32;
        checks++; if (frame_count !== 8'd32) begin errors++; $display("FAIL blink_frame32: got %0d want 32", frame_count); end
        checks++; if ({red, green, blue} !== 12'h000) begin errors++; $display("FAIL blink_hidden: got %h want 000", {red, green, blue}); end
        drv_smem = 4'b0010;
        tick(); tick(); tick(); tick();
        checks++; if ({red, green, blue} !== 12'hF80) begin errors++; $display("FAIL blink_no_attr: got %h want f80", {red, green, blue}); end
`else
        checks++; if (bmem_addr !== 12'hA00) begin errors++; $display("FAIL char_full_index: got %h want a00", bmem_addr); end
        checks++; if ({red, green, blue} !== 12'hF80) begin errors++; $display("FAIL char_rgb: got %h want f80", {red, green, blue}); end
`endif
        drv_smem = 4'h3;
    endtask

    task automatic test_scoreboard();
        int          xs [7] = '{0, 15, 16, 300, 639, 700, 799};
        int          ys [5] = '{0, 17, 255, 479, 480};
        logic [13:0] exp_q [$];
        logic [13:0] want;
        int          px, py, addr;
        logic        act, hs, attr;
        logic [3:0]  ch;
        logic [11:0] baddr, col;
        int          n = 35;
        use_model = 1'b1;
        vsync_in  = 1'b1;
        for (int w = 0; w < n + 2; w++) begin
            if (w < n) begin
                px   = xs[w % 7];
                py   = ys[w / 7];
                act  = (px < 640) && (py < 480);
                hs   = !(px >= 656 && px < 752);
                addr = act ? (py / 16) * 40 + (px / 16) : 0;
                ch   = smem_mem[addr];
                attr = 1'b0;
`ifdef VGA_TILE_BLINK_EN
                attr  = ch[3];
                ch[3] = 1'b0;
`endif
                baddr = {ch, 4'(py % 16), 4'(px % 16)};
                col   = act ? bmem_mem[baddr] : 12'h000;
                if (attr && (exp_frame & 32) != 0) col = 12'h000;
                exp_q.push_back({col, hs, 1'b1});
                set_pix(px, py, act);
                hsync_in = hs;
            end else begin
                set_pix(0, 480, 1'b0);
                hsync_in = 1'b1;
            end
            tick(); tick(); tick();
            if (w >= 1 && exp_q.size() > 0) begin
                want = exp_q.pop_front();
                checks++;
                if ({red, green, blue, hsync, vsync} !== want) begin
                    errors++;
                    $display("FAIL scoreboard_pix%0d: got rgb=%h hs=%b vs=%b want rgb=%h hs=%b vs=%b",
                             w - 1, {red, green, blue}, hsync, vsync, want[13:2], want[1], want[0]);
                end
            end
            tick();
        end
        checks++; if (frame_count !== 8'(exp_frame)) begin errors++; $display("FAIL scoreboard_frame: got %0d want %0d", frame_count, exp_frame); end
        use_model = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) smem_mem[i] = 4'(i * 5 + 3);
        for (int j = 0; j < 4096; j++) bmem_mem[j] = 12'((j * 37 + 11) ^ (j >> 2));
        use_model      = 1'b0;
        drv_smem       = 4'h3;
        drv_bmem       = 12'hF80;
        reset_n        = 1'b0;
        x              = '0;
        y              = '0;
        hsync_in       = 1'b1;
        vsync_in       = 1'b1;
        activevideo_in = 1'b0;

        test_reset();
        test_addr_latency();
        test_sync();
        test_reset_mid();
        test_frame_count();
        test_char_index();
        test_scoreboard();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
